// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive-side buffer that sits directly after the UART receiver. The receiver
// cannot be stalled, so every rx_dv pulse is either stored or counted as
// dropped. Stored words are presented first-word-fall-through on a valid/ready
// stream. RTS-style flow control is raised when the FIFO is nearly full, and
// sticky overflow plus saturating error counters are kept for host polling.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   rx_d/rx_dv        received word and its one-cycle strobe
//   rx_parity_ok      parity status qualified by rx_dv
//   m_d/m_perr/m_dv   head word, its parity-error flag, head valid
//   m_dr              consumer ready; a pop happens on m_dv & m_dr
//   level, full       occupancy (0..DEPTH) and level == DEPTH
//   rts_n             1 = sender should pause (level >= AF_LEVEL)
//   overflow          sticky flag: a word was lost because the FIFO was full
//   clr_overflow      one-cycle clear of overflow (a same-cycle set wins)
//   perr_cnt          parity-error words seen, saturating at 255
//   drop_cnt          words discarded (full or parity drop), saturating at 255
module uart_rx_fifo #(
    parameter int NR_BITS   = 8,
    parameter int DEPTH     = 16,
    parameter int AF_LEVEL  = 12,
    parameter int DROP_PERR = 0,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NR_BITS-1:0] rx_d,
    input  logic               rx_dv,
    input  logic               rx_parity_ok,
    output logic [NR_BITS-1:0] m_d,
    output logic               m_perr,
    output logic               m_dv,
    input  logic               m_dr,
    output logic [AW:0]        level,
    output logic               full,
    output logic               rts_n,
    output logic               overflow,
    input  logic               clr_overflow,
    output logic [7:0]         perr_cnt,
    output logic [7:0]         drop_cnt
);

    // Each entry holds {perr, data}.
    logic [NR_BITS:0]   mem [DEPTH];

    logic [AW-1:0]      wr_ptr_reg;
    logic [AW-1:0]      rd_ptr_reg;
    logic [AW:0]        level_reg;
    logic [AW:0]        level_next;
    logic               rts_n_reg;
    logic               overflow_reg;
    logic [7:0]         perr_cnt_reg;
    logic [7:0]         drop_cnt_reg;

    logic               full_q;
    logic               perr_hit;
    logic               perr_drop;
    logic               full_drop;
    logic               push;
    logic               pop;

    // Full is taken from registered state only, so a pop in the same cycle
    // does not make room for an incoming word.
    assign full_q    = (level_reg == (AW+1)'(DEPTH));
    assign perr_hit  = rx_dv && !rx_parity_ok;
    assign full_drop = rx_dv && full_q;
    assign perr_drop = perr_hit && (DROP_PERR != 0) && !full_q;
    assign push      = rx_dv && !full_q && !((DROP_PERR != 0) && !rx_parity_ok);
    assign pop       = m_dv && m_dr;

    always_comb begin
        level_next = level_reg;
        if (push && !pop) begin
            level_next = level_reg + (AW+1)'(1);
        end else if (pop && !push) begin
            level_next = level_reg - (AW+1)'(1);
        end
    end

    // Storage has no reset; the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {~rx_parity_ok, rx_d};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            rts_n_reg    <= 1'b0;
            overflow_reg <= 1'b0;
            perr_cnt_reg <= '0;
            drop_cnt_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            level_reg <= level_next;
            rts_n_reg <= (level_next >= (AW+1)'(AF_LEVEL));

            // Set has priority over clear.
            if (full_drop) begin
                overflow_reg <= 1'b1;
            end else if (clr_overflow) begin
                overflow_reg <= 1'b0;
            end

            if (perr_hit && perr_cnt_reg != 8'hFF) begin
                perr_cnt_reg <= perr_cnt_reg + 8'd1;
            end
            // A full FIFO and a parity drop never coincide as separate
            // events: one lost word counts once.
            if ((full_drop || perr_drop) && drop_cnt_reg != 8'hFF) begin
                drop_cnt_reg <= drop_cnt_reg + 8'd1;
            end
        end
    end

    assign m_d      = mem[rd_ptr_reg][NR_BITS-1:0];
    assign m_perr   = mem[rd_ptr_reg][NR_BITS];
    assign m_dv     = (level_reg != '0);
    assign level    = level_reg;
    assign full     = full_q;
    assign rts_n    = rts_n_reg;
    assign overflow = overflow_reg;
    assign perr_cnt = perr_cnt_reg;
    assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo. Instance a stores parity-error words,
// instance b (DROP_PERR=1) discards them.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;

    logic [7:0] rx_d_a, rx_d_b;
    logic       rx_dv_a, rx_dv_b, ok_a, ok_b;
    logic [7:0] m_d_a, m_d_b;
    logic       m_perr_a, m_perr_b, m_dv_a, m_dv_b, m_dr_a, m_dr_b;
    logic [4:0] level_a, level_b;
    logic       full_a, full_b, rts_n_a, rts_n_b, ovf_a, ovf_b, clr_a, clr_b;
    logic [7:0] perr_a, perr_b, drop_a, drop_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.NR_BITS(8), .DEPTH(16), .AF_LEVEL(12), .DROP_PERR(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .rx_d(rx_d_a), .rx_dv(rx_dv_a),
        .rx_parity_ok(ok_a), .m_d(m_d_a), .m_perr(m_perr_a), .m_dv(m_dv_a),
        .m_dr(m_dr_a), .level(level_a), .full(full_a), .rts_n(rts_n_a),
        .overflow(ovf_a), .clr_overflow(clr_a), .perr_cnt(perr_a), .drop_cnt(drop_a)
    );

    uart_rx_fifo #(.NR_BITS(8), .DEPTH(16), .AF_LEVEL(12), .DROP_PERR(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx_d(rx_d_b), .rx_dv(rx_dv_b),
        .rx_parity_ok(ok_b), .m_d(m_d_b), .m_perr(m_perr_b), .m_dv(m_dv_b),
        .m_dr(m_dr_b), .level(level_b), .full(full_b), .rts_n(rts_n_b),
        .overflow(ovf_b), .clr_overflow(clr_b), .perr_cnt(perr_b), .drop_cnt(drop_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_a(input logic [7:0] d, input logic ok);
        rx_d_a  = d;
        ok_a    = ok;
        rx_dv_a = 1'b1;
        step();
        rx_dv_a = 1'b0;
        ok_a    = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        rx_d_a = '0; rx_dv_a = 0; ok_a = 1; m_dr_a = 0; clr_a = 0;
        rx_d_b = '0; rx_dv_b = 0; ok_b = 1; m_dr_b = 0; clr_b = 0;
        step();
        step();
        rst_n = 1'b1;

        // Reset state
        chk("rst_level", level_a, 0);
        chk("rst_m_dv", m_dv_a, 0);
        chk("rst_full", full_a, 0);
        chk("rst_rts_n", rts_n_a, 0);
        chk("rst_overflow", ovf_a, 0);
        chk("rst_perr_cnt", perr_a, 0);
        chk("rst_drop_cnt", drop_a, 0);

        // 1: three writes, then drain in order
        write_a(8'h11, 1);
        chk("t1_first_dv", m_dv_a, 1);
        write_a(8'h22, 1);
        write_a(8'h33, 1);
        chk("t1_level", level_a, 3);
        chk("t1_head", m_d_a, 8'h11);
        chk("t1_head_perr", m_perr_a, 0);
        m_dr_a = 1;
        chk("t1_pop0", m_d_a, 8'h11);
        step();
        chk("t1_pop1", m_d_a, 8'h22);
        step();
        chk("t1_pop2", m_d_a, 8'h33);
        step();
        chk("t1_empty_dv", m_dv_a, 0);
        chk("t1_empty_level", level_a, 0);
        step();  // m_dr while empty is ignored
        chk("t1_ignored_pop", level_a, 0);
        m_dr_a = 0;

        // 2: fill to 16, rts_n at 12, then overflow
        for (int i = 0; i < 16; i++) begin
            write_a(8'h40 + 8'(i), 1);
            if (i == 10) chk("t2_rts_n_11", rts_n_a, 0);
            if (i == 11) chk("t2_rts_n_12", rts_n_a, 1);
            if (i == 14) chk("t2_not_full_15", full_a, 0);
        end
        chk("t2_full", full_a, 1);
        chk("t2_level16", level_a, 16);
        write_a(8'hEE, 1);
        chk("t2_overflow", ovf_a, 1);
        chk("t2_drop_cnt", drop_a, 1);
        chk("t2_level_after", level_a, 16);
        chk("t2_head", m_d_a, 8'h40);

        // 3: pop + write while full -> word dropped
        m_dr_a = 1;
        write_a(8'hDD, 1);
        m_dr_a = 0;
        chk("t3_level15", level_a, 15);
        chk("t3_drop_cnt", drop_a, 2);
        chk("t3_overflow", ovf_a, 1);
        chk("t3_head", m_d_a, 8'h41);
        write_a(8'h50, 1);
        chk("t3_refull", full_a, 1);
        clr_a = 1;
        write_a(8'hCC, 1);
        clr_a = 0;
        chk("t3_set_beats_clr", ovf_a, 1);
        chk("t3_drop_cnt3", drop_a, 3);
        clr_a = 1;
        step();
        clr_a = 0;
        chk("t3_cleared", ovf_a, 0);
        m_dr_a = 1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t3_drain%0d", i), m_d_a, 8'h41 + 8'(i));
            step();
        end
        m_dr_a = 0;
        chk("t3_drained", level_a, 0);

        // 4a: parity error stored (DROP_PERR=0)
        write_a(8'hA5, 0);
        chk("t4a_level", level_a, 1);
        chk("t4a_data", m_d_a, 8'hA5);
        chk("t4a_perr", m_perr_a, 1);
        chk("t4a_perr_cnt", perr_a, 1);
        chk("t4a_drop_cnt", drop_a, 3);
        m_dr_a = 1;
        step();
        m_dr_a = 0;
        chk("t4a_popped", level_a, 0);

        // 4b: parity error dropped (DROP_PERR=1), then saturation
        rx_d_b = 8'hA5; ok_b = 0; rx_dv_b = 1;
        step();
        chk("t4b_level", level_b, 0);
        chk("t4b_m_dv", m_dv_b, 0);
        chk("t4b_perr_cnt", perr_b, 1);
        chk("t4b_drop_cnt", drop_b, 1);
        for (int i = 0; i < 299; i++) step();
        rx_dv_b = 0; ok_b = 1;
        chk("t4b_perr_sat", perr_b, 255);
        chk("t4b_drop_sat", drop_b, 255);
        chk("t4b_level_end", level_b, 0);

        // 5: steady push + pop at level 5, pointers wrap
        for (int i = 0; i < 5; i++) write_a(8'h60 + 8'(i), 1);
        chk("t5_level_start", level_a, 5);
        m_dr_a = 1;
        rx_dv_a = 1;
        ok_a = 1;
        for (int k = 0; k < 40; k++) begin
            rx_d_a = 8'h65 + 8'(k);
            chk($sformatf("t5_order%0d", k), m_d_a, 8'h60 + 8'(k));
            step();
            chk($sformatf("t5_level%0d", k), level_a, 5);
        end
        rx_dv_a = 0;
        m_dr_a = 0;
        chk("t5_head_end", m_d_a, 8'h88);
        chk("t5_rts_n", rts_n_a, 0);

        // 6: reset mid-operation
        for (int i = 0; i < 5; i++) write_a(8'h70 + 8'(i), 1);
        chk("t6_level10", level_a, 10);
        rst_n = 0;
        step();
        rst_n = 1;
        chk("t6_level", level_a, 0);
        chk("t6_m_dv", m_dv_a, 0);
        chk("t6_rts_n", rts_n_a, 0);
        chk("t6_perr_cnt", perr_a, 0);
        chk("t6_drop_cnt", drop_a, 0);
        chk("t6_b_perr_cnt", perr_b, 0);
        write_a(8'h99, 1);
        chk("t6_head", m_d_a, 8'h99);
        chk("t6_head_dv", m_dv_a, 1);
        chk("t6_level1", level_a, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
